// File: rtl/sys_mem_responder.sv
// System-memory responder for the CVP14 bus: zero-fill after reset, single-word
// read/write per cycle, fixed-latency read pipeline and a sticky protocol-error flag.
module sys_mem_responder #(
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned READ_LAT = 1,
    parameter logic [15:0] FILL_VAL = 16'h0000
) (
    input  logic        Clk1,
    input  logic        Reset_n,
    input  logic [15:0] Addr,
    input  logic        RD,
    input  logic        WR,
    input  logic [15:0] DataIn,
    output logic [15:0] DataOut,
    output logic        Valid,
    output logic        Ready,
    output logic        Err
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [ADDR_W:0]     DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DEPTH - 1);
    localparam logic [DATA_W-1:0]   OOR_DATA  = 16'hFFFF;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [IDX_W-1:0]    r_ptr;
    logic [IDX_W-1:0]    w_ptr_next;

    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_in_range;
    logic [IDX_W-1:0]    w_idx;
    logic                w_mem_we;
    logic [IDX_W-1:0]    w_mem_addr;
    logic [DATA_W-1:0]   w_mem_wd;
    logic                w_rd_valid;
    logic [DATA_W-1:0]   w_rd_data;
    logic                w_err_set;

    logic                r_pv [READ_LAT];
    logic [DATA_W-1:0]   r_pd [READ_LAT];
    logic                r_ready;
    logic                r_err;

    // Address is compared at full width; no aliasing into the storage index.
    assign w_in_range = ({1'b0, Addr} < DEPTH_EXT);
    assign w_idx      = Addr[IDX_W-1:0];

    always_ff @(posedge Clk1 or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= ST_INIT;
            r_ptr   <= '0;
        end else begin
            r_state <= w_next_state;
            r_ptr   <= w_ptr_next;
        end
    end

    // Next-state, fill sequencing and RUN request decode.
    always_comb begin
        w_next_state = r_state;
        w_ptr_next   = r_ptr;
        w_mem_we     = 1'b0;
        w_mem_addr   = w_idx;
        w_mem_wd     = DataIn;
        w_rd_valid   = 1'b0;
        w_rd_data    = r_mem[w_idx];
        w_err_set    = 1'b0;

        case (r_state)
            ST_INIT: begin
                w_mem_we   = 1'b1;
                w_mem_addr = r_ptr;
                w_mem_wd   = FILL_VAL;
                if (r_ptr == LAST_IDX) begin
                    w_next_state = ST_RUN;
                end else begin
                    w_ptr_next = r_ptr + IDX_W'(1);
                end
                if (RD || WR) begin
                    w_err_set = 1'b1;
                end
            end
            ST_RUN: begin
                case ({RD, WR})
                    2'b10: begin
                        w_rd_valid = 1'b1;
                        if (!w_in_range) begin
                            w_rd_data = OOR_DATA;
                            w_err_set = 1'b1;
                        end
                    end
                    2'b01: begin
                        if (w_in_range) begin
                            w_mem_we = 1'b1;
                        end else begin
                            w_err_set = 1'b1;
                        end
                    end
                    2'b11: begin
                        w_err_set = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
            default: begin
                w_next_state = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge Clk1) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wd;
        end
    end

    // Read pipeline: data stages only load on a valid token so DataOut holds during bubbles.
    always_ff @(posedge Clk1 or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int unsigned i = 0; i < READ_LAT; i++) begin
                r_pv[i] <= 1'b0;
                r_pd[i] <= '0;
            end
        end else begin
            r_pv[0] <= w_rd_valid;
            if (w_rd_valid) begin
                r_pd[0] <= w_rd_data;
            end
            for (int unsigned i = 1; i < READ_LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                if (r_pv[i-1]) begin
                    r_pd[i] <= r_pd[i-1];
                end
            end
        end
    end

    always_ff @(posedge Clk1 or negedge Reset_n) begin
        if (!Reset_n) begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ready <= (w_next_state == ST_RUN);
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    assign Valid   = r_pv[READ_LAT-1];
    assign DataOut = r_pd[READ_LAT-1];
    assign Ready   = r_ready;
    assign Err     = r_err;

endmodule

// File: tb/tb_sys_mem_responder.sv
// Directed bench for sys_mem_responder: two DEPTH=16 instances (READ_LAT 1 and 3)
// share one stimulus stream; expected values are hand-derived per step.
module tb_sys_mem_responder;

    localparam logic [15:0] FILL1 = 16'h0000;
    localparam logic [15:0] FILL3 = 16'h5A5A;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] addr;
    logic [15:0] din;
    logic        rd;
    logic        wr;
    logic [15:0] do1, do3;
    logic        v1, v3, rdy1, rdy3, e1, e3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sys_mem_responder #(.DEPTH(16), .READ_LAT(1), .FILL_VAL(FILL1)) u_lat1 (
        .Clk1(clk), .Reset_n(rst_n), .Addr(addr), .RD(rd), .WR(wr), .DataIn(din),
        .DataOut(do1), .Valid(v1), .Ready(rdy1), .Err(e1)
    );

    sys_mem_responder #(.DEPTH(16), .READ_LAT(3), .FILL_VAL(FILL3)) u_lat3 (
        .Clk1(clk), .Reset_n(rst_n), .Addr(addr), .RD(rd), .WR(wr), .DataIn(din),
        .DataOut(do3), .Valid(v3), .Ready(rdy3), .Err(e3)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        rd    = 1'b0;
        wr    = 1'b0;
        addr  = '0;
        din   = '0;
        repeat (3) tick;

        // Reset state
        chk("rst_ready1", 16'(rdy1), 16'(0));
        chk("rst_ready3", 16'(rdy3), 16'(0));
        chk("rst_valid1", 16'(v1), 16'(0));
        chk("rst_valid3", 16'(v3), 16'(0));
        chk("rst_err1", 16'(e1), 16'(0));
        chk("rst_err3", 16'(e3), 16'(0));
        chk("rst_dout1", do1, 16'h0000);
        chk("rst_dout3", do3, 16'h0000);

        // INIT lasts DEPTH cycles
        rst_n = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick;
            chk("init_ready1", 16'(rdy1), 16'(i == 16));
            chk("init_ready3", 16'(rdy3), 16'(i == 16));
        end
        chk("init_err1", 16'(e1), 16'(0));
        chk("init_err3", 16'(e3), 16'(0));

        // Read every address after fill
        for (int a = 0; a < 18; a++) begin
            rd   = (a < 16);
            addr = 16'(a);
            tick;
            chk("fill_v1", 16'(v1), 16'(a < 16));
            if (a < 16) chk("fill_d1", do1, FILL1);
            chk("fill_v3", 16'(v3), 16'(a >= 2));
            if (a >= 2) chk("fill_d3", do3, FILL3);
        end
        rd = 1'b0;
        chk("fill_err1", 16'(e1), 16'(0));
        chk("fill_err3", 16'(e3), 16'(0));

        // Read-after-write
        wr = 1'b1; addr = 16'd5; din = 16'hBEEF;
        tick;
        wr = 1'b0; rd = 1'b1;
        tick;
        chk("raw_v1", 16'(v1), 16'(1));
        chk("raw_d1", do1, 16'hBEEF);
        chk("raw_v3_early", 16'(v3), 16'(0));
        rd = 1'b0;
        tick;
        chk("raw_v1_bubble", 16'(v1), 16'(0));
        chk("raw_d1_hold", do1, 16'hBEEF);
        tick;
        chk("raw_v3", 16'(v3), 16'(1));
        chk("raw_d3", do3, 16'hBEEF);
        tick;
        chk("raw_v3_bubble", 16'(v3), 16'(0));
        chk("raw_d3_hold", do3, 16'hBEEF);

        // Write 0x1000+a, then a 16-word read burst
        for (int a = 0; a < 16; a++) begin
            wr = 1'b1; addr = 16'(a); din = 16'h1000 + 16'(a);
            tick;
        end
        wr = 1'b0;
        for (int a = 0; a < 19; a++) begin
            rd   = (a < 16);
            addr = 16'(a);
            tick;
            chk("burst_v1", 16'(v1), 16'(a < 16));
            if (a < 16) chk("burst_d1", do1, 16'h1000 + 16'(a));
            chk("burst_v3", 16'(v3), 16'((a >= 2) && (a < 18)));
            if ((a >= 2) && (a < 18)) chk("burst_d3", do3, 16'h1000 + 16'(a - 2));
        end
        rd = 1'b0;
        chk("burst_d3_hold", do3, 16'h100F);
        chk("burst_err1", 16'(e1), 16'(0));

        // Out-of-range read, then RD+WR collision
        rd = 1'b1; addr = 16'd16;
        tick;
        chk("oor_v1", 16'(v1), 16'(1));
        chk("oor_d1", do1, 16'hFFFF);
        chk("oor_err1", 16'(e1), 16'(1));
        wr = 1'b1; addr = 16'd2; din = 16'hDEAD;
        tick;
        chk("coll_v1", 16'(v1), 16'(0));
        chk("coll_d1_hold", do1, 16'hFFFF);
        wr = 1'b0;
        tick;
        chk("coll_rd2_v1", 16'(v1), 16'(1));
        chk("coll_rd2_d1", do1, 16'h1002);
        chk("oor_v3", 16'(v3), 16'(1));
        chk("oor_d3", do3, 16'hFFFF);
        chk("oor_err3", 16'(e3), 16'(1));
        rd = 1'b0;
        tick;
        chk("coll_v3", 16'(v3), 16'(0));
        tick;
        chk("coll_rd2_v3", 16'(v3), 16'(1));
        chk("coll_rd2_d3", do3, 16'h1002);

        // Out-of-range write must not alias onto address 0
        wr = 1'b1; addr = 16'd16; din = 16'h7777;
        tick;
        wr = 1'b0; rd = 1'b1; addr = 16'd0;
        tick;
        chk("oorwr_v1", 16'(v1), 16'(1));
        chk("oorwr_d1", do1, 16'h1000);
        rd = 1'b0;

        // Reset, then RD held through INIT
        rst_n = 1'b0;
        #1;
        chk("rst2_v1", 16'(v1), 16'(0));
        chk("rst2_err1", 16'(e1), 16'(0));
        chk("rst2_ready1", 16'(rdy1), 16'(0));
        chk("rst2_d1", do1, 16'h0000);
        rd = 1'b1; addr = 16'd0;
        tick;
        rst_n = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick;
            chk("initrd_v1", 16'(v1), 16'(0));
            chk("initrd_v3", 16'(v3), 16'(0));
            chk("initrd_ready1", 16'(rdy1), 16'(i == 16));
            chk("initrd_err1", 16'(e1), 16'(1));
            chk("initrd_err3", 16'(e3), 16'(1));
        end
        tick;
        chk("initrd_run_v1", 16'(v1), 16'(1));
        chk("initrd_run_d1", do1, FILL1);
        rd = 1'b0;
        tick;
        tick;
        chk("initrd_run_v3", 16'(v3), 16'(1));
        chk("initrd_run_d3", do3, FILL3);

        // Reset mid-burst with reads in flight
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        repeat (16) tick;
        chk("rst3_ready1", 16'(rdy1), 16'(1));
        wr = 1'b1; addr = 16'd3; din = 16'h3333;
        tick;
        wr = 1'b0; rd = 1'b1; addr = 16'd0;
        tick;
        addr = 16'd1;
        tick;
        rst_n = 1'b0;
        #1;
        chk("midrst_v1", 16'(v1), 16'(0));
        chk("midrst_v3", 16'(v3), 16'(0));
        chk("midrst_ready3", 16'(rdy3), 16'(0));
        rd = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick;
            chk("refill_v1", 16'(v1), 16'(0));
            chk("refill_v3", 16'(v3), 16'(0));
            chk("refill_ready3", 16'(rdy3), 16'(i >= 16));
        end
        chk("refill_err1", 16'(e1), 16'(0));
        chk("refill_err3", 16'(e3), 16'(0));
        rd = 1'b1; addr = 16'd3;
        tick;
        chk("refill_rd_v1", 16'(v1), 16'(1));
        chk("refill_rd_d1", do1, FILL1);
        rd = 1'b0;
        tick;
        tick;
        chk("refill_rd_v3", 16'(v3), 16'(1));
        chk("refill_rd_d3", do3, FILL3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
